// File: rtl/ex_stage.sv
// Execute stage: forwarding mux, single-cycle ALU, and a 16-cycle shift-add multiplier.
// Latency 1 for ALU ops, 17 edges for MUL; out_stall holds buf2 while the multiplier runs.
module ex_stage (
  input  logic        CLOCK,
  input  logic        in_rst,
  input  logic        in_valid_buf2,
  input  logic [15:0] in_instr_buf2,
  input  logic [15:0] in_op1_buf2,
  input  logic [15:0] in_op2_buf2,
  input  logic [1:0]  in_cntrl_m2,
  input  logic [1:0]  in_cntrl_m3,
  input  logic [15:0] in_wb_data,
  input  logic [15:0] in_mem_data,
  input  logic        in_flush,
  output logic [15:0] out_alu_out_buf3,
  output logic [15:0] out_instr_buf3,
  output logic        out_valid_buf3,
  output logic        out_zero_buf3,
  output logic        out_stall
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL = 4'b0110, OP_MUL = 4'b0111, OP_LD  = 4'b1100,
                         OP_ST  = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state;
  logic [15:0] op_a, op_b, alu_res;
  logic [15:0] mul_a, mul_b, acc, acc_next;
  logic [15:0] mul_instr;
  logic [3:0]  cnt;
  logic [3:0]  opcode;

  function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] rf,
                                      input logic [15:0] wb, input logic [15:0] mem,
                                      input logic [15:0] buf3);
    case (sel)
      2'b11:   fwd = rf;
      2'b01:   fwd = wb;
      2'b00:   fwd = mem;
      default: fwd = buf3;
    endcase
  endfunction

  assign opcode = in_instr_buf2[15:12];
  assign op_a   = fwd(in_cntrl_m2, in_op1_buf2, in_wb_data, in_mem_data, out_alu_out_buf3);
  assign op_b   = fwd(in_cntrl_m3, in_op2_buf2, in_wb_data, in_mem_data, out_alu_out_buf3);

  always_comb begin
    alu_res = 16'h0000;
    case (opcode)
      OP_ADD, OP_LD, OP_ST: alu_res = op_a + op_b;
      OP_SUB:               alu_res = op_a - op_b;
      OP_AND:               alu_res = op_a & op_b;
      OP_OR:                alu_res = op_a | op_b;
      OP_XOR:               alu_res = op_a ^ op_b;
      OP_SLL:               alu_res = op_a << op_b[3:0];
      OP_SRL:               alu_res = op_a >> op_b[3:0];
      default:              alu_res = 16'h0000;
    endcase
  end

  // One multiplier bit per edge, LSB first; mul_a is pre-shifted so only the low bit of mul_b matters.
  assign acc_next  = acc + (mul_b[0] ? mul_a : 16'h0000);
  assign out_stall = (state == MUL);

  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      acc              <= 16'h0000;
      mul_a            <= 16'h0000;
      mul_b            <= 16'h0000;
      mul_instr        <= 16'h0000;
      out_alu_out_buf3 <= 16'h0000;
      out_instr_buf3   <= 16'h0000;
      out_valid_buf3   <= 1'b0;
      out_zero_buf3    <= 1'b0;
    end else if (in_flush) begin
      state          <= IDLE;
      out_valid_buf3 <= 1'b0;
    end else if (state == IDLE) begin
      if (!in_valid_buf2) begin
        out_valid_buf3 <= 1'b0;
      end else if (opcode == OP_MUL) begin
        mul_a          <= op_a;
        mul_b          <= op_b;
        mul_instr      <= in_instr_buf2;
        acc            <= 16'h0000;
        cnt            <= 4'd0;
        out_valid_buf3 <= 1'b0;
        state          <= MUL;
      end else begin
        out_alu_out_buf3 <= alu_res;
        out_instr_buf3   <= in_instr_buf2;
        out_valid_buf3   <= 1'b1;
        out_zero_buf3    <= (alu_res == 16'h0000);
      end
    end else begin
      acc   <= acc_next;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + 4'd1;
      if (cnt == 4'd15) begin
        out_alu_out_buf3 <= acc_next;
        out_instr_buf3   <= mul_instr;
        out_valid_buf3   <= 1'b1;
        out_zero_buf3    <= (acc_next == 16'h0000);
        state            <= IDLE;
      end else begin
        out_valid_buf3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, multiplier timing, flush and reset.
module tb_ex_stage;
  logic        CLOCK = 1'b0;
  logic        in_rst, in_valid_buf2, in_flush;
  logic [15:0] in_instr_buf2, in_op1_buf2, in_op2_buf2, in_wb_data, in_mem_data;
  logic [1:0]  in_cntrl_m2, in_cntrl_m3;
  logic [15:0] out_alu_out_buf3, out_instr_buf3;
  logic        out_valid_buf3, out_zero_buf3, out_stall;

  int ncmp = 0;
  int nerr = 0;

  ex_stage dut (
    .CLOCK(CLOCK), .in_rst(in_rst), .in_valid_buf2(in_valid_buf2),
    .in_instr_buf2(in_instr_buf2), .in_op1_buf2(in_op1_buf2), .in_op2_buf2(in_op2_buf2),
    .in_cntrl_m2(in_cntrl_m2), .in_cntrl_m3(in_cntrl_m3), .in_wb_data(in_wb_data),
    .in_mem_data(in_mem_data), .in_flush(in_flush), .out_alu_out_buf3(out_alu_out_buf3),
    .out_instr_buf3(out_instr_buf3), .out_valid_buf3(out_valid_buf3),
    .out_zero_buf3(out_zero_buf3), .out_stall(out_stall)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [1:0] m2, input logic [1:0] m3,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid_buf2 = 1'b1;
    in_instr_buf2 = instr;
    in_cntrl_m2   = m2;
    in_cntrl_m3   = m3;
    in_op1_buf2   = a;
    in_op2_buf2   = b;
  endtask

  logic [15:0] t_instr [10];
  logic [15:0] t_a     [10];
  logic [15:0] t_b     [10];
  logic [15:0] t_exp   [10];

  initial begin
    in_rst = 1'b1; in_flush = 1'b0; in_valid_buf2 = 1'b0;
    in_instr_buf2 = 16'h0; in_op1_buf2 = 16'h0; in_op2_buf2 = 16'h0;
    in_cntrl_m2 = 2'b11; in_cntrl_m3 = 2'b11; in_wb_data = 16'h0; in_mem_data = 16'h0;

    step(); step();
    chk("rst_alu", out_alu_out_buf3, 16'h0000);
    chk("rst_instr", out_instr_buf3, 16'h0000);
    chk("rst_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("rst_zero", {15'd0, out_zero_buf3}, 16'd0);
    chk("rst_stall", {15'd0, out_stall}, 16'd0);
    in_rst = 1'b0;

    drive(16'h0123, 2'b11, 2'b11, 16'h7FFF, 16'h0001);
    step();
    chk("add_res", out_alu_out_buf3, 16'h8000);
    chk("add_valid", {15'd0, out_valid_buf3}, 16'd1);
    chk("add_zero", {15'd0, out_zero_buf3}, 16'd0);
    chk("add_instr", out_instr_buf3, 16'h0123);

    in_wb_data = 16'h0005; in_mem_data = 16'h0005;
    drive(16'h1456, 2'b01, 2'b00, 16'hAAAA, 16'h1111);
    step();
    chk("sub_res", out_alu_out_buf3, 16'h0000);
    chk("sub_zero", {15'd0, out_zero_buf3}, 16'd1);

    drive(16'h0111, 2'b11, 2'b11, 16'h0010, 16'h0020);
    step();
    chk("byp_first", out_alu_out_buf3, 16'h0030);
    drive(16'h0222, 2'b10, 2'b11, 16'h9999, 16'h0005);
    step();
    chk("byp_second", out_alu_out_buf3, 16'h0035);

    in_valid_buf2 = 1'b0;
    in_instr_buf2 = 16'h2000;
    step();
    chk("bubble_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("bubble_res", out_alu_out_buf3, 16'h0035);
    chk("bubble_instr", out_instr_buf3, 16'h0222);

    t_instr[0] = 16'h2000; t_a[0] = 16'hF0F0; t_b[0] = 16'h0FF0; t_exp[0] = 16'h00F0;
    t_instr[1] = 16'h3000; t_a[1] = 16'hF000; t_b[1] = 16'h000F; t_exp[1] = 16'hF00F;
    t_instr[2] = 16'h4000; t_a[2] = 16'hFFFF; t_b[2] = 16'h00FF; t_exp[2] = 16'hFF00;
    t_instr[3] = 16'h5000; t_a[3] = 16'h0001; t_b[3] = 16'h0014; t_exp[3] = 16'h0010;
    t_instr[4] = 16'h6000; t_a[4] = 16'h8000; t_b[4] = 16'h0003; t_exp[4] = 16'h1000;
    t_instr[5] = 16'hC000; t_a[5] = 16'h1000; t_b[5] = 16'h0234; t_exp[5] = 16'h1234;
    t_instr[6] = 16'hD000; t_a[6] = 16'hFFFF; t_b[6] = 16'h0002; t_exp[6] = 16'h0001;
    t_instr[7] = 16'h8000; t_a[7] = 16'h1234; t_b[7] = 16'h5678; t_exp[7] = 16'h0000;
    t_instr[8] = 16'h1000; t_a[8] = 16'h0000; t_b[8] = 16'h0001; t_exp[8] = 16'hFFFF;
    t_instr[9] = 16'h0000; t_a[9] = 16'hFFFF; t_b[9] = 16'h0001; t_exp[9] = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      drive(t_instr[i], 2'b11, 2'b11, t_a[i], t_b[i]);
      step();
      chk($sformatf("op%0d_res", i), out_alu_out_buf3, t_exp[i]);
      chk($sformatf("op%0d_zero", i), {15'd0, out_zero_buf3}, {15'd0, t_exp[i] == 16'h0000});
      chk($sformatf("op%0d_valid", i), {15'd0, out_valid_buf3}, 16'd1);
    end

    // MUL with A forwarded from WB; WB changes afterwards must not matter.
    in_wb_data = 16'h0123;
    drive(16'h7456, 2'b01, 2'b11, 16'hBEEF, 16'h0045);
    step();
    chk("mul_e0_stall", {15'd0, out_stall}, 16'd1);
    chk("mul_e0_valid", {15'd0, out_valid_buf3}, 16'd0);
    in_wb_data = 16'h0001;
    drive(16'h0789, 2'b10, 2'b01, 16'h7777, 16'h3333);
    for (int e = 1; e <= 15; e++) begin
      step();
      chk($sformatf("mul_e%0d_stall", e), {15'd0, out_stall}, 16'd1);
      chk($sformatf("mul_e%0d_valid", e), {15'd0, out_valid_buf3}, 16'd0);
    end
    step();
    chk("mul_res", out_alu_out_buf3, 16'h4E6F);
    chk("mul_valid", {15'd0, out_valid_buf3}, 16'd1);
    chk("mul_instr", out_instr_buf3, 16'h7456);
    chk("mul_stall_drop", {15'd0, out_stall}, 16'd0);
    step();
    chk("held_add_res", out_alu_out_buf3, 16'h4E70);
    chk("held_add_instr", out_instr_buf3, 16'h0789);
    chk("held_add_valid", {15'd0, out_valid_buf3}, 16'd1);

    drive(16'h7000, 2'b11, 2'b11, 16'h0003, 16'h0004);
    step();
    in_valid_buf2 = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    chk("flush_pre_stall", {15'd0, out_stall}, 16'd1);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    chk("flush_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("flush_stall", {15'd0, out_stall}, 16'd0);
    for (int e = 0; e < 20; e++) step();
    chk("flush_nowrite_res", out_alu_out_buf3, 16'h4E70);
    chk("flush_nowrite_valid", {15'd0, out_valid_buf3}, 16'd0);

    drive(16'h0ABC, 2'b11, 2'b11, 16'h0001, 16'h0001);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    in_valid_buf2 = 1'b0;
    chk("idle_flush_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("idle_flush_res", out_alu_out_buf3, 16'h4E70);

    drive(16'h7001, 2'b11, 2'b11, 16'h0003, 16'h0004);
    step();
    step(); step(); step();
    in_rst = 1'b1; in_flush = 1'b1;
    step();
    in_rst = 1'b0; in_flush = 1'b0; in_valid_buf2 = 1'b0;
    chk("rstmul_alu", out_alu_out_buf3, 16'h0000);
    chk("rstmul_instr", out_instr_buf3, 16'h0000);
    chk("rstmul_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("rstmul_zero", {15'd0, out_zero_buf3}, 16'd0);
    chk("rstmul_stall", {15'd0, out_stall}, 16'd0);
    for (int e = 0; e < 18; e++) step();
    chk("rstmul_late_valid", {15'd0, out_valid_buf3}, 16'd0);
    chk("rstmul_late_alu", out_alu_out_buf3, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port in_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port in_valid_buf2  in  1  ID/EX buffer holds a live instruction.
REQ-004 SHALL have port in_instr_buf2  in  16  opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0].
REQ-005 SHALL have ports in_op1_buf2, in_op2_buf2  in  16 each  register-file operand values.
REQ-006 SHALL have ports in_cntrl_m2, in_cntrl_m3  in  2 each  operand-1 / operand-2 forward selects.
REQ-007 SHALL have port in_wb_data  in  16  ALU result in WB stage.
REQ-008 SHALL have port in_mem_data  in  16  load data in WB stage.
REQ-009 SHALL have port in_flush  in  1  kill in-flight EX work.
REQ-010 SHALL have port out_alu_out_buf3  out  16  registered EX/MEM result.
REQ-011 SHALL have port out_instr_buf3  out  16  registered instruction copy.
REQ-012 SHALL have port out_valid_buf3  out  1  buf3 contents live.
REQ-013 SHALL have port out_zero_buf3  out  1  registered result==0.
REQ-014 SHALL have port out_stall  out  1  upstream holds buf2 while high.

Function
REQ-015 Operand select per bit pair SHALL be: 11 register file, 01 in_wb_data, 00 in_mem_data, 10 out_alu_out_buf3; m2 drives op A, m3 drives op B.
REQ-016 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL by B[3:0], 0110 SRL by B[3:0], 0111 MUL, 1100 LOAD (A+B address), 1101 STORE (A+B address); all others NOP with result 0.
REQ-017 Arithmetic SHALL be 16-bit modulo 2^16; carry/overflow discarded; MUL keeps low 16 bits of product.
REQ-018 Single-cycle ops SHALL register result, instr, valid=1, zero flag at the edge that consumes buf2 (latency 1).
REQ-019 in_valid_buf2=0 SHALL register valid=0, result and instr unchanged.
REQ-020 FSM SHALL have states IDLE and MUL; out_stall = (state==MUL), combinational from state only.
REQ-021 IDLE with valid MUL: at edge E0 latch selected A, B, instr; clear accumulator and 4-bit counter; go MUL; out_valid_buf3 <= 0.
REQ-022 MUL: edges E1..E16 shift-add one multiplier bit LSB-first; at E16 write product, instr, valid=1, zero flag; go IDLE.
REQ-023 During MUL, buf2 inputs and forward selects SHALL be ignored; out_valid_buf3 held 0.
REQ-024 Operands for MUL SHALL be those forwarded at E0; later WB changes SHALL NOT affect result.
REQ-025 in_flush at any edge SHALL force out_valid_buf3<=0, state<=IDLE, abort MUL; buf2 at that edge not consumed.
REQ-026 Back-to-back: instruction held under stall SHALL be consumed at the first edge after E16 using selects present then.

Reset
REQ-027 in_rst at an edge SHALL set out_alu_out_buf3=0, out_instr_buf3=0, out_valid_buf3=0, out_zero_buf3=0, state IDLE, counter 0, so out_stall=0 next cycle.
REQ-028 in_rst SHALL take precedence over in_flush and any in-flight MUL.

Verification
REQ-029 ADD, selects 11/11, op1=0x7FFF, op2=0x0001 -> next edge result 0x8000, valid=1, zero=0.
REQ-030 SUB, m2=01 in_wb_data=0x0005, m3=00 in_mem_data=0x0005 -> result 0x0000, zero=1.
REQ-031 ADD then ADD with m2=10 -> second result uses first result (bypass from buf3).
REQ-032 MUL A=0x0123 B=0x0045 -> out_stall high 16 cycles, valid=0 during, then result 0x4E6F valid=1; held ADD then completes one edge later.
REQ-033 MUL issued, in_flush at E5 -> valid stays 0, stall drops next cycle, no result written.
REQ-034 in_rst asserted mid-MUL with in_flush also high -> all outputs 0, stall 0 after that edge.
